// File: rtl/rom_loader_pkg.sv
// rom_loader_pkg: shared types and helpers for the ROM boot loader.
//   REG_W       - register/bus width used for ROM write address and data
//   ld_state_e  - loader state encoding (LD_IDLE, LD_COLLECT, LD_WRITE, LD_DONE)
//   put_byte    - replace one byte lane of a word (lane 0 = bits [7:0])
package rom_loader_pkg;

    localparam int REG_W = 32;

    typedef enum logic [1:0] {
        LD_IDLE    = 2'd0,
        LD_COLLECT = 2'd1,
        LD_WRITE   = 2'd2,
        LD_DONE    = 2'd3
    } ld_state_e;

    function automatic logic [REG_W-1:0] put_byte(
        input logic [REG_W-1:0] w,
        input logic [1:0]       idx,
        input logic [7:0]       b
    );
        logic [REG_W-1:0] r;
        r = w;
        r[{idx, 3'b000} +: 8] = b;
        return r;
    endfunction

endpackage

// File: rtl/rom_ld_timer.sv
// rom_ld_timer: clear/enable idle-cycle counter with terminal count at TIMEOUT-1.
//   clk, rstn - clock, asynchronous active-low reset
//   clr_i     - synchronous clear (takes priority over en_i)
//   en_i      - count enable
//   tc_o      - counter currently equals TIMEOUT-1
module rom_ld_timer #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = clr_i ? '0 : en_i ? cnt_q + W'(1) : cnt_q;

    always_ff @(posedge clk or negedge rstn)
        if (!rstn) cnt_q <= '0;
        else       cnt_q <= cnt_d;

    assign tc_o = (cnt_q == W'(TIMEOUT - 1));

endmodule

// File: rtl/rom_loader.sv
// rom_loader: packs a byte stream into 32-bit words and writes them to the instruction ROM.
//   clk, rstn            - clock, asynchronous active-low reset
//   start                - one-cycle load request, honoured only when idle
//   base_addr, word_cnt  - first word byte address (low 2 bits ignored), number of words
//   byte_valid/byte_data - incoming stream, accepted when byte_ready is high
//   wen, w_addr, w_data  - single-cycle ROM write per assembled word
//   busy                 - load in progress (holds the core in reset)
//   done                 - one-cycle completion pulse
//   err                  - sticky timeout flag, cleared by the next accepted start
module rom_loader
    import rom_loader_pkg::*;
#(
    parameter int LEN_W   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [REG_W-1:0] base_addr,
    input  logic [LEN_W-1:0] word_cnt,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    output logic             byte_ready,
    output logic             wen,
    output logic [REG_W-1:0] w_addr,
    output logic [REG_W-1:0] w_data,
    output logic             busy,
    output logic             done,
    output logic             err
);

    ld_state_e        state_q, state_d;
    logic [REG_W-1:0] addr_q, addr_d;
    logic [REG_W-1:0] word_q, word_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [1:0]       idx_q, idx_d;
    logic             err_q, err_d;
    logic             hs, tmr_clr, tmr_tc;

    assign hs = byte_valid && byte_ready;
    // The timer only runs on idle COLLECT cycles; any other state restarts it.
    assign tmr_clr = (state_q != LD_COLLECT) || hs;

    rom_ld_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk   (clk),
        .rstn  (rstn),
        .clr_i (tmr_clr),
        .en_i  (!tmr_clr),
        .tc_o  (tmr_tc)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        word_d  = word_q;
        rem_d   = rem_q;
        idx_d   = idx_q;
        err_d   = err_q;
        case (state_q)
            LD_IDLE: begin
                if (start) begin
                    err_d = 1'b0;
                    if (word_cnt != '0) begin
                        addr_d  = base_addr & ~REG_W'(3);
                        rem_d   = word_cnt;
                        idx_d   = 2'd0;
                        state_d = LD_COLLECT;
                    end else begin
                        state_d = LD_DONE;
                    end
                end
            end
            LD_COLLECT: begin
                if (hs) begin
                    word_d = put_byte(word_q, idx_q, byte_data);
                    idx_d  = idx_q + 2'd1;
                    if (idx_q == 2'd3) state_d = LD_WRITE;
                end else if (tmr_tc) begin
                    err_d   = 1'b1;
                    word_d  = '0;
                    idx_d   = 2'd0;
                    state_d = LD_IDLE;
                end
            end
            LD_WRITE: begin
                addr_d  = addr_q + REG_W'(4);
                rem_d   = rem_q - LEN_W'(1);
                idx_d   = 2'd0;
                state_d = (rem_q == LEN_W'(1)) ? LD_DONE : LD_COLLECT;
            end
            default: state_d = LD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= LD_IDLE;
            addr_q  <= '0;
            word_q  <= '0;
            rem_q   <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            word_q  <= word_d;
            rem_q   <= rem_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
        end
    end

    // Outputs are decoded from registered state only, so reset clears them at once.
    assign byte_ready = (state_q == LD_COLLECT);
    assign wen        = (state_q == LD_WRITE);
    assign w_addr     = addr_q;
    assign w_data     = word_q;
    assign busy       = (state_q != LD_IDLE);
    assign done       = (state_q == LD_DONE);
    assign err        = err_q;

endmodule
